iic_oled_driver: RTL and testbench
==================================

// Module: iic_oled_driver
// PURPOSE
//   Byte-level I2C master, downstream of the OLED sequencer. Each accepted request is one
//   complete write: START, slave address + W, control byte (command or data), payload byte,
//   STOP. Handshake via iic_exec / iic_done. Drives an open-drain SCL/SDA pair to an SSD1306-class panel.
// PARAMETERS
//   CLK_FREQ    50_000_000  sys_clk frequency, Hz
//   IIC_FREQ    400_000     SCL frequency, Hz; QTR = CLK_FREQ/(4*IIC_FREQ), must be >= 2
//   SLAVE_ADDR  7'h3C       7-bit slave address (address byte on wire = 8'h78)
//   CMD_CTRL    8'h00       control byte sent when iic_w_ctrl = 1 (command)
//   DATA_CTRL   8'h40       control byte sent when iic_w_ctrl = 0 (GDDRAM data)
// PORTS
//   sys_clk     in   1  sole clock
//   sys_rst     in   1  synchronous, active-high reset
//   iic_exec    in   1  request; sampled only while iic_done = 1
//   iic_w_ctrl  in   1  1 = command byte, 0 = data byte; latched on accept
//   iic_w_data  in   8  payload byte; latched on accept
//   iic_done    out  1  1 = idle/ready, 0 = transaction in progress
//   iic_ack_err out  1  sticky NACK flag for the last transaction
//   iic_scl     out  1  SCL (push-pull high; no clock stretching supported)
//   iic_sda_oe  out  1  1 = pull SDA low; 0 = release (top level ties inout as open drain)
//   iic_sda_i   in   1  SDA pin readback, used in ACK slots only
// BEHAVIOUR
//   Reset: iic_scl=1, iic_sda_oe=0, iic_done=1, iic_ack_err=0, FSM=IDLE, divider=0.
//   Reset mid-transaction aborts at once to reset values; no STOP is generated.
//   Timing: a free-running divider emits a tick every QTR cycles while busy and is cleared in IDLE.
//     One bit = 4 ticks (phases): P0 SCL low, drive SDA; P1 SCL rises; P2 SCL high,
//     sample iic_sda_i in ACK slots; P3 SCL falls.
//   Accept: the cycle iic_exec=1 & iic_done=1 latches ctrl/data, clears iic_ack_err,
//     and takes FSM to START. iic_done=0 from the next cycle. iic_exec while busy is ignored.
//   FSM: IDLE -> START -> ADDR(8) -> ACK1 -> CTRL(8) -> ACK2 -> DATA(8) -> ACK3 -> STOP -> IDLE
//     START: SCL high, SDA released then pulled low at P2 (falling SDA with SCL high); 1 bit-time.
//     ADDR/CTRL/DATA: MSB first; bit=0 -> sda_oe=1, bit=1 -> sda_oe=0; 3-bit bit counter 7..0.
//     ACKn: sda_oe=0. At P2, iic_sda_i=1 (NACK) sets iic_ack_err and jumps to STOP.
//     STOP: SDA low at P0, SCL high at P1, SDA released at P2 (rising SDA with SCL high); 1 bit-time.
//   Completion: after STOP P3 the FSM returns to IDLE and iic_done=1 the next cycle.
//     Total busy time with no NACK = 29 bit-times = 116*QTR cycles (+/-1).
//   Back-to-back: iic_exec held high starts a new transaction the first cycle iic_done=1.
//     iic_done therefore shows a 1-cycle-high pulse between transfers; the sequencer
//     counts on its falling edge.
//   SDA changes only while SCL is low, except the START and STOP edges.
//   iic_ack_err stays set until the next accept or reset.
// TESTING (CLK_FREQ=4_000_000, IIC_FREQ=250_000 -> QTR=4; slave model ACKs unless stated)
//   Command 8'hAE, ctrl=1 -> decoded wire bytes 78,00,AE; START/STOP seen; done low 464 +/-1 cycles; ack_err=0.
//   Data 8'hF0, ctrl=0 -> wire bytes 78,40,F0; SDA stable while SCL high except START/STOP.
//   Slave NACKs the address -> ack_err=1; STOP follows ACK1; CTRL/DATA bytes absent; done returns high.
//   Second exec pulse 50 cycles into a transfer -> ignored; only one 3-byte frame appears on the wire.
//   Exec held high for 3 transfers -> three frames; 1-cycle done-high gap between them; latched bytes correct.
//   sys_rst asserted during DATA bit 3 -> next cycle scl=1, sda_oe=0, done=1, ack_err=0; next exec is a clean frame.

Source files
------------

// File: rtl/iic_oled_if.sv
// Request/handshake and open-drain pin signals between the OLED sequencer, the I2C
// byte driver and the pad. The driver uses the slave modport.
interface iic_oled_if;
    logic       iic_exec;
    logic       iic_w_ctrl;
    logic [7:0] iic_w_data;
    logic       iic_done;
    logic       iic_ack_err;
    logic       iic_scl;
    logic       iic_sda_oe;
    logic       iic_sda_i;

    modport master (
        output iic_exec, iic_w_ctrl, iic_w_data, iic_sda_i,
        input  iic_done, iic_ack_err, iic_scl, iic_sda_oe
    );

    modport slave (
        input  iic_exec, iic_w_ctrl, iic_w_data, iic_sda_i,
        output iic_done, iic_ack_err, iic_scl, iic_sda_oe
    );
endinterface

// File: rtl/iic_oled_driver.sv
// Byte-level I2C write master for an SSD1306-class panel: each request sends
// START, address+W, control byte, payload byte, STOP on an open-drain SCL/SDA pair.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready, iic_done=1, divider held at 0
// S_START | SCL high, SDA pulled low at P2
// S_ADDR  | slave address + W, MSB first
// S_ACK1  | address ACK slot, NACK aborts to STOP
// S_CTRL  | control byte (command or data)
// S_ACK2  | control ACK slot
// S_DATA  | payload byte
// S_ACK3  | payload ACK slot
// S_STOP  | SDA low, SCL high, then SDA released
module iic_oled_driver #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned IIC_FREQ   = 400_000,
    parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
    parameter logic [7:0]  CMD_CTRL   = 8'h00,
    parameter logic [7:0]  DATA_CTRL  = 8'h40
) (
    input logic        sys_clk,
    input logic        sys_rst,
    iic_oled_if.slave  bus
);

    localparam int unsigned QTR       = CLK_FREQ / (4 * IIC_FREQ);
    localparam int unsigned DIV_W     = $clog2(QTR);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(QTR - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [7:0] ADDR_BYTE  = {SLAVE_ADDR, 1'b0};

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_CTRL, S_ACK2, S_DATA, S_ACK3, S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       bit_q, bit_d;
    logic             ctrl_q, ctrl_d;
    logic [7:0]       data_q, data_d;
    logic             ack_err_q, ack_err_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;

    logic             tick;
    logic             bit_end;
    logic [7:0]       byte_cur;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        ctrl_d    = ctrl_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;

        tick    = (div_q == '0);
        bit_end = tick && (phase_q == 2'd3);

        case (state_q)
            S_CTRL:  byte_cur = ctrl_q ? CMD_CTRL : DATA_CTRL;
            S_DATA:  byte_cur = data_q;
            default: byte_cur = ADDR_BYTE;
        endcase

        if (state_q != S_IDLE) begin
            div_d = tick ? DIV_LOAD : (div_q - DIV_ONE);
            if (tick) begin
                phase_d = phase_q + 2'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                div_d   = '0;
                phase_d = 2'd0;
                if (bus.iic_exec) begin
                    ctrl_d    = bus.iic_w_ctrl;
                    data_d    = bus.iic_w_data;
                    ack_err_d = 1'b0;
                    div_d     = DIV_LOAD;
                    state_d   = S_START;
                end
            end
            S_START: begin
                scl_d    = (phase_q != 2'd3);
                sda_oe_d = phase_q[1];
                if (bit_end) begin
                    bit_d   = 3'd7;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_CTRL, S_DATA: begin
                scl_d    = phase_q[0] ^ phase_q[1];
                sda_oe_d = ~byte_cur[bit_q];
                if (bit_end) begin
                    // bit_q wraps 0 -> 7, ready for the next byte
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) begin
                        case (state_q)
                            S_ADDR:  state_d = S_ACK1;
                            S_CTRL:  state_d = S_ACK2;
                            default: state_d = S_ACK3;
                        endcase
                    end
                end
            end
            S_ACK1, S_ACK2, S_ACK3: begin
                scl_d = phase_q[0] ^ phase_q[1];
                if (tick && (phase_q == 2'd2) && bus.iic_sda_i) begin
                    ack_err_d = 1'b1;
                end
                if (bit_end) begin
                    if (ack_err_q || (state_q == S_ACK3)) begin
                        state_d = S_STOP;
                    end else if (state_q == S_ACK1) begin
                        state_d = S_CTRL;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_STOP: begin
                scl_d    = (phase_q != 2'd0);
                sda_oe_d = ~phase_q[1];
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd7;
            ctrl_q    <= 1'b0;
            data_q    <= 8'h00;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    // Pins come straight from flops so SCL/SDA never glitch on state decode
    assign bus.iic_done    = (state_q == S_IDLE);
    assign bus.iic_ack_err = ack_err_q;
    assign bus.iic_scl     = scl_q;
    assign bus.iic_sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_iic_oled_driver.sv
// Scoreboard bench for iic_oled_driver: stimulus queues expected wire frames and
// completion status; a bus monitor with an ACKing slave model decodes and checks them.
module tb_iic_oled_driver;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic slave_pull = 1'b0;
    int   nack_sel = -1;
    int   checks = 0;
    int   errors = 0;

    iic_oled_if bus();
    assign bus.iic_sda_i = ~(bus.iic_sda_oe | slave_pull);

    iic_oled_driver #(
        .CLK_FREQ (4_000_000),
        .IIC_FREQ (250_000)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { logic [23:0] bytes; int n; } frame_t;
    typedef struct { logic err; int busy; } done_t;

    frame_t frame_q[$];
    done_t  done_q[$];

    // monitor state
    logic        scl_prev = 1'b1;
    logic        sda_prev = 1'b1;
    logic        done_prev = 1'b1;
    logic        sda_now;
    logic        in_frame = 1'b0;
    int          bitpos = 0;
    int          nbytes = 0;
    logic [7:0]  cur = 8'h00;
    logic [23:0] obs = 24'h0;
    int          busy_cnt = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        frame_t f;
        done_t  d;
        forever begin
            @(negedge sys_clk);
            sda_now = bus.iic_sda_i;
            if (sys_rst) begin
                in_frame   = 1'b0;
                bitpos     = 0;
                nbytes     = 0;
                slave_pull = 1'b0;
                busy_cnt   = 0;
            end else begin
                if (scl_prev && bus.iic_scl && sda_prev && !sda_now) begin
                    checks++;
                    if (in_frame) begin
                        errors++;
                        $display("FAIL start_in_frame: got START after %0d bytes, want none", nbytes);
                    end
                    in_frame = 1'b1;
                    bitpos   = 0;
                    nbytes   = 0;
                    obs      = 24'h0;
                end else if (scl_prev && bus.iic_scl && !sda_prev && sda_now) begin
                    checks++;
                    if (frame_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got n=%0d bytes=%h, want no frame", nbytes, obs);
                    end else begin
                        f = frame_q.pop_front();
                        if (nbytes != f.n || obs != f.bytes) begin
                            errors++;
                            $display("FAIL frame: got n=%0d bytes=%h, want n=%0d bytes=%h",
                                     nbytes, obs, f.n, f.bytes);
                        end
                    end
                    in_frame = 1'b0;
                end else if (in_frame && !scl_prev && bus.iic_scl) begin
                    if (bitpos < 8) begin
                        cur = {cur[6:0], sda_now};
                        bitpos++;
                    end else begin
                        obs = {obs[15:0], cur};
                        nbytes++;
                        bitpos = 0;
                    end
                end else if (in_frame && scl_prev && !bus.iic_scl) begin
                    if (bitpos == 8) begin
                        slave_pull = (nack_sel != nbytes);
                    end else if (bitpos == 0) begin
                        slave_pull = 1'b0;
                    end
                end

                if (!bus.iic_done) begin
                    busy_cnt++;
                end else if (!done_prev) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done rise, want none");
                    end else begin
                        d = done_q.pop_front();
                        checks++;
                        if (bus.iic_ack_err !== d.err) begin
                            errors++;
                            $display("FAIL ack_err: got %b, want %b", bus.iic_ack_err, d.err);
                        end
                        checks++;
                        if (busy_cnt < d.busy - 1 || busy_cnt > d.busy + 1) begin
                            errors++;
                            $display("FAIL busy_len: got %0d cycles, want %0d +/-1", busy_cnt, d.busy);
                        end
                    end
                    busy_cnt = 0;
                end
            end
            scl_prev  = bus.iic_scl;
            sda_prev  = sda_now;
            done_prev = bus.iic_done;
        end
    end

    task automatic push_exp(input logic [23:0] bytes, input int n, input logic err, input int busy);
        frame_t f;
        done_t  d;
        f.bytes = bytes;
        f.n     = n;
        d.err   = err;
        d.busy  = busy;
        frame_q.push_back(f);
        done_q.push_back(d);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.iic_done !== 1'b1 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        if (bus.iic_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got done=%b, want 1 within 2000 cycles", tag, bus.iic_done);
        end
    endtask

    task automatic run(input logic ctrl, input logic [7:0] data, input int nack_at,
                       input logic [23:0] bytes, input int n, input logic err, input int busy);
        push_exp(bytes, n, err, busy);
        wait_idle("pre");
        nack_sel        = nack_at;
        bus.iic_w_ctrl  = ctrl;
        bus.iic_w_data  = data;
        bus.iic_exec    = 1'b1;
        @(negedge sys_clk);
        bus.iic_exec    = 1'b0;
        wait_idle("run");
        @(negedge sys_clk);
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    initial begin
        bus.iic_exec   = 1'b0;
        bus.iic_w_ctrl = 1'b0;
        bus.iic_w_data = 8'h00;
        repeat (3) @(negedge sys_clk);
        check1("rst_scl", bus.iic_scl, 1'b1);
        check1("rst_sda_oe", bus.iic_sda_oe, 1'b0);
        check1("rst_done", bus.iic_done, 1'b1);
        check1("rst_ack_err", bus.iic_ack_err, 1'b0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // command, data, NACK on address, NACK on control byte
        run(1'b1, 8'hAE, -1, 24'h7800AE, 3, 1'b0, 464);
        run(1'b0, 8'hF0, -1, 24'h7840F0, 3, 1'b0, 464);
        run(1'b1, 8'h8D,  0, 24'h000078, 1, 1'b1, 176);
        run(1'b0, 8'h3C,  1, 24'h007840, 2, 1'b1, 320);

        // exec pulse while busy must be ignored
        push_exp(24'h7800A5, 3, 1'b0, 464);
        wait_idle("ign_pre");
        nack_sel       = -1;
        bus.iic_w_ctrl = 1'b1;
        bus.iic_w_data = 8'hA5;
        bus.iic_exec   = 1'b1;
        @(negedge sys_clk);
        bus.iic_exec   = 1'b0;
        repeat (49) @(negedge sys_clk);
        bus.iic_w_ctrl = 1'b0;
        bus.iic_w_data = 8'h55;
        bus.iic_exec   = 1'b1;
        @(negedge sys_clk);
        bus.iic_exec   = 1'b0;
        wait_idle("ign_run");
        repeat (20) @(negedge sys_clk);
        check1("done_after_ignore", bus.iic_done, 1'b1);

        // exec held high across three back-to-back transfers
        push_exp(24'h780081, 3, 1'b0, 464);
        push_exp(24'h7800CF, 3, 1'b0, 464);
        push_exp(24'h784055, 3, 1'b0, 464);
        wait_idle("b2b_pre");
        bus.iic_w_ctrl = 1'b1;
        bus.iic_w_data = 8'h81;
        bus.iic_exec   = 1'b1;
        @(negedge sys_clk);
        bus.iic_w_data = 8'hCF;
        wait_idle("b2b_1");
        @(negedge sys_clk);
        check1("b2b_gap1", bus.iic_done, 1'b0);
        bus.iic_w_ctrl = 1'b0;
        bus.iic_w_data = 8'h55;
        wait_idle("b2b_2");
        @(negedge sys_clk);
        check1("b2b_gap2", bus.iic_done, 1'b0);
        bus.iic_exec   = 1'b0;
        wait_idle("b2b_3");
        @(negedge sys_clk);

        // reset during DATA bit 3 aborts immediately
        wait_idle("rst_pre");
        bus.iic_w_ctrl = 1'b1;
        bus.iic_w_data = 8'h99;
        bus.iic_exec   = 1'b1;
        @(negedge sys_clk);
        bus.iic_exec   = 1'b0;
        repeat (374) @(negedge sys_clk);
        check1("busy_before_rst", bus.iic_done, 1'b0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check1("abort_scl", bus.iic_scl, 1'b1);
        check1("abort_sda_oe", bus.iic_sda_oe, 1'b0);
        check1("abort_done", bus.iic_done, 1'b1);
        check1("abort_ack_err", bus.iic_ack_err, 1'b0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        run(1'b1, 8'hAF, -1, 24'h7800AF, 3, 1'b0, 464);

        repeat (50) @(negedge sys_clk);
        checks++;
        if (frame_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d frames %0d completions outstanding, want 0 0",
                     frame_q.size(), done_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
